// File: rtl/soc_it_message_send_arbiter.sv
// Round-robin arbiter sharing one SoC-IT message send port among NUM_REQ requesters.
// Defining SOC_IT_MSG_ARB_TIMEOUT_EN adds an ack timeout in REQ (error 2'b11 after ACK_TIMEOUT cycles).
module soc_it_message_send_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = $clog2(NUM_REQ),
  parameter int ACK_TIMEOUT = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     s_send_msg_request,
  output logic [NUM_REQ-1:0]     s_send_msg_ack,
  output logic [NUM_REQ-1:0]     s_send_msg_complete,
  output logic [NUM_REQ*2-1:0]   s_send_msg_error,
  input  logic [NUM_REQ-1:0]     s_send_msg_src_rdy,
  output logic [NUM_REQ-1:0]     s_send_msg_dst_rdy,
  input  logic [NUM_REQ*128-1:0] s_send_msg_payload,
  output logic                   m_send_msg_request,
  input  logic                   m_send_msg_ack,
  input  logic                   m_send_msg_complete,
  input  logic [1:0]             m_send_msg_error,
  output logic                   m_send_msg_src_rdy,
  input  logic                   m_send_msg_dst_rdy,
  output logic [127:0]           m_send_msg_payload,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id
);

  if (NUM_REQ < 2 || ACK_TIMEOUT < 1) begin : g_bad_params
    $error("soc_it_message_send_arbiter: NUM_REQ must be >= 2 and ACK_TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e                 state_q;
  logic [ID_W-1:0]        winner_q;
  logic [ID_W-1:0]        last_grant_q;
  logic [ID_W-1:0]        grant_id_q;
  logic                   m_req_q;
  logic                   busy_q;
  logic [NUM_REQ-1:0]     s_ack_q;
  logic [NUM_REQ-1:0]     s_cmpl_q;
  logic [NUM_REQ*2-1:0]   s_err_q;
  logic [ID_W-1:0]        winner_d;
  logic [NUM_REQ-1:0]     win_mask_s;
  logic                   m_src_rdy_s;
  logic [127:0]           m_payload_s;
  logic [NUM_REQ-1:0]     s_dst_rdy_s;

`ifdef SOC_IT_MSG_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  logic [TMO_W-1:0]       tmo_cnt_q;
`endif

  // First requesting index above last, wrapping; returns last when nothing requests.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [ID_W-1:0]    last);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = last;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last) + off) % NUM_REQ;
      if (!found && req[idx[ID_W-1:0]]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_REQ-1:0] sel_mask(input logic [ID_W-1:0] w);
    logic [NUM_REQ-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  assign winner_d   = rr_pick(s_send_msg_request, last_grant_q);
  assign win_mask_s = sel_mask(winner_q);

  // Message FSM with registered handshake outputs; the winner is frozen from REQ until IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      winner_q     <= '0;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      m_req_q      <= 1'b0;
      busy_q       <= 1'b0;
      s_ack_q      <= '0;
      s_cmpl_q     <= '0;
      s_err_q      <= '0;
`ifdef SOC_IT_MSG_ARB_TIMEOUT_EN
      tmo_cnt_q    <= '0;
`endif
    end else begin
      s_ack_q  <= '0;
      s_cmpl_q <= '0;
      s_err_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|s_send_msg_request) begin
            winner_q   <= winner_d;
            grant_id_q <= winner_d;
            m_req_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_REQ;
`ifdef SOC_IT_MSG_ARB_TIMEOUT_EN
            tmo_cnt_q  <= '0;
`endif
          end else begin
            m_req_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (m_send_msg_ack) begin
            m_req_q <= 1'b0;
            s_ack_q <= win_mask_s;
            state_q <= ST_XFER;
          end
`ifdef SOC_IT_MSG_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1)) begin
            m_req_q  <= 1'b0;
            s_cmpl_q <= win_mask_s;
            for (int i = 0; i < NUM_REQ; i++) begin
              s_err_q[2*i +: 2] <= win_mask_s[i] ? 2'b11 : 2'b00;
            end
            state_q  <= ST_DONE;
          end
`endif
          else begin
            m_req_q   <= 1'b1;
            state_q   <= ST_REQ;
`ifdef SOC_IT_MSG_ARB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
`endif
          end
        end
        ST_XFER: begin
          if (m_send_msg_complete) begin
            s_cmpl_q <= win_mask_s;
            for (int i = 0; i < NUM_REQ; i++) begin
              s_err_q[2*i +: 2] <= win_mask_s[i] ? m_send_msg_error : 2'b00;
            end
            state_q  <= ST_DONE;
          end else begin
            state_q <= ST_XFER;
          end
        end
        ST_DONE: begin
          last_grant_q <= winner_q;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          m_req_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Zero-latency beat steering, only while transferring.
  always_comb begin
    m_src_rdy_s = 1'b0;
    m_payload_s = '0;
    s_dst_rdy_s = '0;
    if (state_q == ST_XFER) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (win_mask_s[i]) begin
          m_src_rdy_s    = s_send_msg_src_rdy[i];
          m_payload_s    = s_send_msg_payload[128*i +: 128];
          s_dst_rdy_s[i] = m_send_msg_dst_rdy;
        end else begin
          s_dst_rdy_s[i] = 1'b0;
        end
      end
    end else begin
      m_src_rdy_s = 1'b0;
    end
  end

  assign s_send_msg_ack      = s_ack_q;
  assign s_send_msg_complete = s_cmpl_q;
  assign s_send_msg_error    = s_err_q;
  assign s_send_msg_dst_rdy  = s_dst_rdy_s;
  assign m_send_msg_request  = m_req_q;
  assign m_send_msg_src_rdy  = m_src_rdy_s;
  assign m_send_msg_payload  = m_payload_s;
  assign busy                = busy_q;
  assign grant_id            = grant_id_q;

endmodule

// File: doc/soc_it_message_send_arbiter.md
# soc_it_message_send_arbiter

Shares one SoC-IT message send port among `NUM_REQ` requesters. Arbitration is round-robin at message granularity. The arbiter grants one requester and forwards its request downstream. It then steers that requester's payload beats to the port until the downstream completes, and returns complete/error to the winner. It sits between the application's message producers and the single `soc_it_message_send_ports` instance.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; must be ≥ 2.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the grant index.
- `ACK_TIMEOUT`, default 256: ack wait limit in cycles. Used only with `SOC_IT_MSG_ARB_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `s_send_msg_request`, in, `NUM_REQ`: per-requester message request.
- `s_send_msg_ack`, out, `NUM_REQ`: per-requester ack pulse.
- `s_send_msg_complete`, out, `NUM_REQ`: per-requester completion pulse.
- `s_send_msg_error`, out, `NUM_REQ*2`: per-requester error code, slice `[2i+1:2i]`.
- `s_send_msg_src_rdy`, in, `NUM_REQ`: per-requester beat valid.
- `s_send_msg_dst_rdy`, out, `NUM_REQ`: per-requester beat accept.
- `s_send_msg_payload`, in, `NUM_REQ*128`: per-requester payload, slice `[128i+127:128i]`.
- `m_send_msg_request`, out, 1: request to the downstream send port.
- `m_send_msg_ack`, in, 1: downstream ack.
- `m_send_msg_complete`, in, 1: downstream completion.
- `m_send_msg_error`, in, 2: downstream error code, valid with complete.
- `m_send_msg_src_rdy`, out, 1: beat valid to downstream.
- `m_send_msg_dst_rdy`, in, 1: downstream beat accept.
- `m_send_msg_payload`, out, 128: payload to downstream.
- `busy`, out, 1: high whenever state ≠ IDLE.
- `grant_id`, out, `ID_W`: index of the current/last granted requester.

## Operation
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE:
  - If any `s_send_msg_request` bit is high, latch winner = first requester with a high request, searching upward (with wrap) from `last_grant+1`.
  - Go to REQ.
- REQ:
  - `m_send_msg_request`=1, registered.
  - On `m_send_msg_ack`=1: go to XFER. `m_send_msg_request` drops the next cycle, and `s_send_msg_ack[winner]` pulses for exactly 1 cycle.
- XFER: pure combinational steering by the registered winner.
  - `m_send_msg_src_rdy` = `s_send_msg_src_rdy[winner]`.
  - `m_send_msg_payload` = `s_send_msg_payload[winner]`.
  - `s_send_msg_dst_rdy[winner]` = `m_send_msg_dst_rdy`; all other `dst_rdy` bits are 0.
  - A beat transfers when src_rdy && dst_rdy.
  - On `m_send_msg_complete`=1: latch `m_send_msg_error` and go to DONE. A beat in the same cycle as complete still transfers.
- DONE:
  - `s_send_msg_complete[winner]`=1 for 1 cycle, with the latched error on its slice.
  - `last_grant` ← winner; go to IDLE.
- Outside XFER: `m_send_msg_src_rdy`=0, `m_send_msg_payload`=0, all `s_send_msg_dst_rdy`=0.
- Requester rules:
  - A requester holds request high until its ack and drops it within 1 cycle after the ack.
  - A request still high in IDLE is a new message.
  - A request dropped during REQ is ignored; the message proceeds.
- `m_send_msg_complete` seen outside XFER is ignored.
- The winner cannot change until the FSM returns to IDLE.

## Timing
- Reset values, all outputs 0: requests, acks, completes, errors, src/dst_rdy, payload, `busy`, `grant_id`.
- Reset state: IDLE, `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
- Reset asserted mid-message returns the block to IDLE immediately. No ack/complete is issued for the aborted message.
- Request to grant: request high in IDLE at cycle 0 → `m_send_msg_request` high at cycle 1.
- Downstream ack seen at cycle k → `s_send_msg_ack` pulse at k+1; XFER steering active from k+1.
- Downstream complete seen at cycle c → `s_send_msg_complete` at c+1 → IDLE at c+2.
- Minimum message overhead is 4 cycles; back-to-back grants have one IDLE cycle between messages.
- Data path latency through the arbiter is 0 cycles (combinational).

## Configuration
- `SOC_IT_MSG_ARB_TIMEOUT_EN` defined:
  - A counter runs while in REQ.
  - If `ACK_TIMEOUT` cycles elapse without `m_send_msg_ack`, drop `m_send_msg_request`, skip XFER, and go to DONE with error 2'b11. No `s_send_msg_ack` is issued.
  - A late downstream ack arriving after the timeout is ignored.
- Not defined: REQ waits indefinitely, no counter logic is built, and `ACK_TIMEOUT` is unused.

## Test plan
- Single requester 2 raises request; downstream acks after 3 cycles; 4 beats; complete with error 2'b00 → `s_ack[2]` one pulse; 4 payloads appear on `m` in order; `s_complete[2]` with error 00; `grant_id`=2.
- Requesters 0, 1, 3 all request continuously from reset → grant order 0,1,3,0,1,3; exactly one IDLE cycle between messages.
- Downstream stalls `dst_rdy` on alternate cycles → no beat lost or duplicated; non-winners' `dst_rdy` stays 0 throughout.
- Complete with error 2'b10 coincident with the last beat → last beat transfers; `s_error` slice of winner = 10 during its complete pulse.
- `rst` driven low during XFER → all outputs 0 asynchronously; after release, requester 0 wins first; no stale complete.
- With `SOC_IT_MSG_ARB_TIMEOUT_EN`, `ACK_TIMEOUT`=16, downstream never acks → `m_request` drops after 16 REQ cycles; `s_complete` with error 11; no `s_ack`; next requester is then granted.
